hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Parametrised forwarding and hazard controller for the 5-stage pipeline (F/D/E/M/W). It generates the ID-stage branch-compare forwards and the EX-stage operand mux selects. It detects load-use, branch-in-ID and multi-cycle mul/div hazards and drives stall and flush. A scoreboard tracks the in-flight mul/div destination, and a saturating counter records stall cycles for performance monitoring.

## Interface
Parameters:
- ADDR_W, 5, register-address width; address 0 is the hard-wired zero register.
- MD_LAT, 4, mul/div latency in cycles (legal range 2..15).
- FWD_EN, 1, 1 = full forwarding; 0 = no forwarding, every RAW hazard stalls.
- CNT_W, 16, stall-counter width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rsD, rtD  in  ADDR_W  ID-stage source registers.
- branchD  in  1  ID-stage instruction is a branch (compares in ID).
- mdReqD  in  1  ID-stage instruction is a mul/div.
- rsE, rtE  in  ADDR_W  EX-stage source registers.
- wrAddrE, regWeE, memToRegE  in  ADDR_W/1/1  EX destination, write enable, load flag.
- mdStartE  in  1  mul/div launches this cycle.
- mdDestE  in  ADDR_W  mul/div destination register.
- wrAddrM, regWeM, memToRegM  in  ADDR_W/1/1  MEM destination, write enable, load flag.
- wrAddrW, regWeW  in  ADDR_W/1  WB destination, write enable.
- perfClr  in  1  synchronous clear of the stall counter.
- forwardAD, forwardBD  out  1  ID compare operand taken from the M-stage ALU result.
- forwardAE, forwardBE  out  2  EX operand select: 00 = regfile, 01 = M stage, 10 = W stage.
- stallF, stallD  out  1  hold PC and the IF/ID register.
- flushE  out  1  insert a bubble into ID/EX.
- mdBusy  out  1  mul/div scoreboard occupied.
- mdDone  out  1  single-cycle pulse in the last busy cycle.
- stallCnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- A match requires a nonzero address, equality, and an asserted write enable of the source stage. Register 0 never matches.
- EX forward (FWD_EN=1): a match against M gives 01; otherwise a match against W gives 10; otherwise 00. M has priority over W.
- ID forward (FWD_EN=1): forwardAD/BD = match of rsD/rtD against M with memToRegM=0.
- With FWD_EN=0, all forward outputs are constant 0.
- The regfile writes in the first half-cycle, so a W-stage match never needs an ID stall.
- The stall term is the OR of the following:
  - loadUse: memToRegE and a match of wrAddrE against rsD or rtD.
  - branch: branchD and either (a match of wrAddrE against rsD/rtD) or (memToRegM and a match of wrAddrM against rsD/rtD).
  - mdRaw: mdBusy and mdDest (nonzero) equals rsD or rtD.
  - mdStruct: mdBusy and mdReqD, unless mdDone is asserted in the same cycle.
  - noFwd (FWD_EN=0 only): rsD/rtD match E or M.
- stallF = stallD = flushE = stall (combinational).
- Scoreboard is a 2-state FSM, IDLE and BUSY, with a down-counter cnt.
  - IDLE, mdStartE: latch mdDestE into mdDest, load cnt = MD_LAT-1, go to BUSY.
  - BUSY: decrement cnt. mdDone = (cnt==0). At cnt==0, go to IDLE, or reload and stay in BUSY if mdStartE is also high.
  - mdStartE while BUSY with cnt≠0: a protocol error. The unit restarts (relatches the destination, reloads cnt) and the result of the first operation is lost.
- Stall counter: perfClr gives 0 (wins over increment). Otherwise stall increments it, saturating at all-ones.

## Timing
- Reset values: state IDLE, cnt=0, mdDest=0, stallCnt=0. As a result mdBusy=0 and mdDone=0. Combinational outputs follow their inputs during reset (scoreboard terms are 0).
- Asserting rst_n low in the middle of an operation aborts a mul/div immediately. No mdDone is issued.
- Forward, stall and flush outputs have zero latency (combinational from inputs and state).
- Scoreboard timing for mdStartE at edge t:
  - mdBusy is high for the MD_LAT cycles after edge t.
  - mdDone is high in the final one of those cycles.
  - A consumer in D is released in the cycle after mdDone. It must not be released in the mdDone cycle itself, because the result reaches WB at the end of that cycle.
- stallCnt updates one edge after a stalled cycle.

## Test plan
- Forward priority: wrAddrM=wrAddrW=5, both regWe=1, rsE=5 -> forwardAE=01. Drop regWeM -> 10. rsE=0 -> 00.
- Load-use: memToRegE=1, regWeE=1, wrAddrE=8, rtD=8 -> stallF=stallD=flushE=1 for exactly one cycle. With the next cycle showing the load in M, the stall is 0 and forwardBE=01.
- Branch hazard: branchD=1, rsD=3, wrAddrE=3 with regWeE=1 -> stall. Next cycle, memToRegM=0 with wrAddrM=3 -> stall=0 and forwardAD=1.
- Mul/div (MD_LAT=4): mdStartE, mdDestE=9 at edge t.
  - Required: mdBusy for 4 cycles, mdDone in the 4th.
  - Required: rsD=9 stalls those 4 cycles, and stallCnt=4 afterwards.
  - Required: mdReqD in the mdDone cycle is not stalled.
- FWD_EN=0: regWeM=1, wrAddrM=2, rsD=2 -> stall=1 and all forward outputs 0.
- Saturation/reset: preset CNT_W=4 and hold stall for 20 cycles -> stallCnt=15. perfClr with stall -> 0. rst_n low during BUSY -> mdBusy=0 immediately.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for the forwarding/hazard controller: register
// addresses, write enables and mul/div controls in, forward selects, stall
// controls and scoreboard status out.
interface hazard_forward_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  // ID stage
  logic [ADDR_W-1:0] rsD;
  logic [ADDR_W-1:0] rtD;
  logic              branchD;
  logic              mdReqD;
  // EX stage
  logic [ADDR_W-1:0] rsE;
  logic [ADDR_W-1:0] rtE;
  logic [ADDR_W-1:0] wrAddrE;
  logic              regWeE;
  logic              memToRegE;
  logic              mdStartE;
  logic [ADDR_W-1:0] mdDestE;
  // MEM stage
  logic [ADDR_W-1:0] wrAddrM;
  logic              regWeM;
  logic              memToRegM;
  // WB stage
  logic [ADDR_W-1:0] wrAddrW;
  logic              regWeW;
  // Performance monitor
  logic              perfClr;
  // Controller outputs
  logic              forwardAD;
  logic              forwardBD;
  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;
  logic              stallF;
  logic              stallD;
  logic              flushE;
  logic              mdBusy;
  logic              mdDone;
  logic [CNT_W-1:0]  stallCnt;

  // Pipeline datapath side
  modport master (
    output rsD, rtD, branchD, mdReqD,
    output rsE, rtE, wrAddrE, regWeE, memToRegE, mdStartE, mdDestE,
    output wrAddrM, regWeM, memToRegM,
    output wrAddrW, regWeW,
    output perfClr,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
    input  stallF, stallD, flushE, mdBusy, mdDone, stallCnt
  );

  // Hazard controller side
  modport slave (
    input  rsD, rtD, branchD, mdReqD,
    input  rsE, rtE, wrAddrE, regWeE, memToRegE, mdStartE, mdDestE,
    input  wrAddrM, regWeM, memToRegM,
    input  wrAddrW, regWeW,
    input  perfClr,
    output forwardAD, forwardBD, forwardAE, forwardBE,
    output stallF, stallD, flushE, mdBusy, mdDone, stallCnt
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and hazard controller for the F/D/E/M/W pipeline: EX operand
// selects, ID branch-compare forwards, load-use / branch / mul-div stalls,
// a single-entry mul/div scoreboard and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned MD_LAT = 4,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_forward_ctrl_if.slave bus
);

  // MD_LAT is at most 15, so four bits hold the reload value
  localparam int unsigned      LAT_W      = 4;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  md_state_e         state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] md_dest_q, md_dest_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       md_busy_c;
  logic       md_done_c;
  logic       stall_c;
  logic       fwd_ad_c;
  logic       fwd_bd_c;
  logic [1:0] fwd_ae_c;
  logic [1:0] fwd_be_c;

  // Register 0 never matches; the producing stage must actually write
  function automatic logic hit(input logic [ADDR_W-1:0] src,
                               input logic [ADDR_W-1:0] dst,
                               input logic              we);
    return (src != '0) && (src == dst) && we;
  endfunction

  // Scoreboard status decoded from the FSM
  always_comb begin
    md_busy_c = (state_q == ST_BUSY);
    md_done_c = md_busy_c && (cnt_q == '0);
  end

  // Operand forwarding: M has priority over W in EX; ID compares only take M ALU results
  always_comb begin
    fwd_ae_c = 2'b00;
    fwd_be_c = 2'b00;
    fwd_ad_c = 1'b0;
    fwd_bd_c = 1'b0;
    if (FWD_EN) begin
      if (hit(bus.rsE, bus.wrAddrM, bus.regWeM))      fwd_ae_c = 2'b01;
      else if (hit(bus.rsE, bus.wrAddrW, bus.regWeW)) fwd_ae_c = 2'b10;
      if (hit(bus.rtE, bus.wrAddrM, bus.regWeM))      fwd_be_c = 2'b01;
      else if (hit(bus.rtE, bus.wrAddrW, bus.regWeW)) fwd_be_c = 2'b10;
      fwd_ad_c = hit(bus.rsD, bus.wrAddrM, bus.regWeM) && !bus.memToRegM;
      fwd_bd_c = hit(bus.rtD, bus.wrAddrM, bus.regWeM) && !bus.memToRegM;
    end
  end

  // Stall decision: OR of every hazard that the forwarding network cannot cover
  always_comb begin
    logic d_hit_e, d_hit_m, ld_use, br_haz, md_raw, md_struct, no_fwd;
    d_hit_e   = hit(bus.rsD, bus.wrAddrE, bus.regWeE) ||
                hit(bus.rtD, bus.wrAddrE, bus.regWeE);
    d_hit_m   = hit(bus.rsD, bus.wrAddrM, bus.regWeM) ||
                hit(bus.rtD, bus.wrAddrM, bus.regWeM);
    ld_use    = bus.memToRegE && d_hit_e;
    br_haz    = bus.branchD && (d_hit_e || (bus.memToRegM && d_hit_m));
    // The consumer waits through the mdDone cycle; the result is in WB only afterwards
    md_raw    = md_busy_c && (md_dest_q != '0) &&
                ((md_dest_q == bus.rsD) || (md_dest_q == bus.rtD));
    md_struct = md_busy_c && bus.mdReqD && !md_done_c;
    no_fwd    = !FWD_EN && (d_hit_e || d_hit_m);
    stall_c   = ld_use || br_haz || md_raw || md_struct || no_fwd;
  end

  // Scoreboard next state: a start always (re)launches, even mid-operation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_dest_d = md_dest_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.mdStartE) begin
          state_d   = ST_BUSY;
          cnt_d     = LAT_RELOAD;
          md_dest_d = bus.mdDestE;
        end
      end
      ST_BUSY: begin
        if (bus.mdStartE) begin
          cnt_d     = LAT_RELOAD;
          md_dest_d = bus.mdDestE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall-cycle counter: clear wins, otherwise count stalls and saturate
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.perfClr) begin
      stall_cnt_d = '0;
    end else if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      md_dest_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_dest_q   <= md_dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.forwardAE = fwd_ae_c;
  assign bus.forwardBE = fwd_be_c;
  assign bus.forwardAD = fwd_ad_c;
  assign bus.forwardBD = fwd_bd_c;
  assign bus.stallF    = stall_c;
  assign bus.stallD    = stall_c;
  assign bus.flushE    = stall_c;
  assign bus.mdBusy    = md_busy_c;
  assign bus.mdDone    = md_done_c;
  assign bus.stallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two instances (full forwarding with a 16-bit
// counter and MD_LAT=4; no forwarding with a 4-bit counter and MD_LAT=3)
// driven from one stimulus set and compared against a cycle-level model.
module tb_hazard_forward_ctrl;

  localparam int unsigned AW    = 5;
  localparam int          LAT0  = 4;
  localparam int          LAT1  = 3;
  localparam int          MAX0  = 65535;
  localparam int          MAX1  = 15;

  logic clk;
  logic rst_n;

  logic [AW-1:0] rsD, rtD, rsE, rtE, wrAddrE, mdDestE, wrAddrM, wrAddrW;
  logic branchD, mdReqD, regWeE, memToRegE, mdStartE;
  logic regWeM, memToRegM, regWeW, perfClr;

  int n_checks;
  int n_fail;

  // Model state: cycles of busy window left, latched destination, stall count
  int            left0, left1;
  logic [AW-1:0] dest0, dest1;
  int            cnt0, cnt1;

  hazard_forward_ctrl_if #(.ADDR_W(AW), .CNT_W(16)) if0 ();
  hazard_forward_ctrl_if #(.ADDR_W(AW), .CNT_W(4))  if1 ();

  hazard_forward_ctrl #(.ADDR_W(AW), .MD_LAT(LAT0), .FWD_EN(1'b1), .CNT_W(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  hazard_forward_ctrl #(.ADDR_W(AW), .MD_LAT(LAT1), .FWD_EN(1'b0), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  assign if0.rsD = rsD;         assign if1.rsD = rsD;
  assign if0.rtD = rtD;         assign if1.rtD = rtD;
  assign if0.branchD = branchD; assign if1.branchD = branchD;
  assign if0.mdReqD = mdReqD;   assign if1.mdReqD = mdReqD;
  assign if0.rsE = rsE;         assign if1.rsE = rsE;
  assign if0.rtE = rtE;         assign if1.rtE = rtE;
  assign if0.wrAddrE = wrAddrE; assign if1.wrAddrE = wrAddrE;
  assign if0.regWeE = regWeE;   assign if1.regWeE = regWeE;
  assign if0.memToRegE = memToRegE; assign if1.memToRegE = memToRegE;
  assign if0.mdStartE = mdStartE;   assign if1.mdStartE = mdStartE;
  assign if0.mdDestE = mdDestE; assign if1.mdDestE = mdDestE;
  assign if0.wrAddrM = wrAddrM; assign if1.wrAddrM = wrAddrM;
  assign if0.regWeM = regWeM;   assign if1.regWeM = regWeM;
  assign if0.memToRegM = memToRegM; assign if1.memToRegM = memToRegM;
  assign if0.wrAddrW = wrAddrW; assign if1.wrAddrW = wrAddrW;
  assign if0.regWeW = regWeW;   assign if1.regWeW = regWeW;
  assign if0.perfClr = perfClr; assign if1.perfClr = perfClr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules
  function automatic bit m(input logic [AW-1:0] a, input logic [AW-1:0] wa, input logic we);
    return (a != 0) && (a == wa) && (we == 1'b1);
  endfunction

  function automatic logic [1:0] fe(input logic [AW-1:0] a);
    if (m(a, wrAddrM, regWeM)) return 2'b01;
    if (m(a, wrAddrW, regWeW)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_stall(input bit fwd, input int left, input logic [AW-1:0] dest);
    bit he, hm, busy, done;
    he   = m(rsD, wrAddrE, regWeE) || m(rtD, wrAddrE, regWeE);
    hm   = m(rsD, wrAddrM, regWeM) || m(rtD, wrAddrM, regWeM);
    busy = left > 0;
    done = left == 1;
    return (memToRegE && he) ||
           (branchD && (he || (memToRegM && hm))) ||
           (busy && dest != 0 && (dest == rsD || dest == rtD)) ||
           (busy && mdReqD && !done) ||
           (!fwd && (he || hm));
  endfunction

  task automatic clear_in();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0; wrAddrE = '0; mdDestE = '0;
    wrAddrM = '0; wrAddrW = '0; branchD = 0; mdReqD = 0; regWeE = 0;
    memToRegE = 0; mdStartE = 0; regWeM = 0; memToRegM = 0; regWeW = 0; perfClr = 0;
  endtask

  // Compare every output of both instances against the model at the falling edge
  task automatic sample();
    bit s0, s1;
    @(negedge clk);
    s0 = exp_stall(1'b1, left0, dest0);
    s1 = exp_stall(1'b0, left1, dest1);
    chk("fwdAE0", 32'(if0.forwardAE), 32'(fe(rsE)));
    chk("fwdBE0", 32'(if0.forwardBE), 32'(fe(rtE)));
    chk("fwdAD0", 32'(if0.forwardAD), 32'(m(rsD, wrAddrM, regWeM) && !memToRegM));
    chk("fwdBD0", 32'(if0.forwardBD), 32'(m(rtD, wrAddrM, regWeM) && !memToRegM));
    chk("stallF0", 32'(if0.stallF), 32'(s0));
    chk("stallD0", 32'(if0.stallD), 32'(s0));
    chk("flushE0", 32'(if0.flushE), 32'(s0));
    chk("mdBusy0", 32'(if0.mdBusy), 32'(left0 > 0));
    chk("mdDone0", 32'(if0.mdDone), 32'(left0 == 1));
    chk("stallCnt0", 32'(if0.stallCnt), 32'(cnt0));
    chk("fwd1_zero", 32'({if1.forwardAE, if1.forwardBE, if1.forwardAD, if1.forwardBD}), 32'(0));
    chk("stallF1", 32'(if1.stallF), 32'(s1));
    chk("stallD1", 32'(if1.stallD), 32'(s1));
    chk("flushE1", 32'(if1.flushE), 32'(s1));
    chk("mdBusy1", 32'(if1.mdBusy), 32'(left1 > 0));
    chk("mdDone1", 32'(if1.mdDone), 32'(left1 == 1));
    chk("stallCnt1", 32'(if1.stallCnt), 32'(cnt1));
  endtask

  // Advance the model across the next rising edge, then return 1 time unit later
  task automatic advance();
    bit s0, s1;
    @(posedge clk);
    s0 = exp_stall(1'b1, left0, dest0);
    s1 = exp_stall(1'b0, left1, dest1);
    if (!rst_n) begin
      left0 = 0; left1 = 0; dest0 = '0; dest1 = '0; cnt0 = 0; cnt1 = 0;
    end else begin
      if (perfClr) cnt0 = 0; else if (s0 && cnt0 < MAX0) cnt0++;
      if (perfClr) cnt1 = 0; else if (s1 && cnt1 < MAX1) cnt1++;
      if (mdStartE) begin left0 = LAT0; dest0 = mdDestE; end
      else if (left0 > 0) left0--;
      if (mdStartE) begin left1 = LAT1; dest1 = mdDestE; end
      else if (left1 > 0) left1--;
    end
    #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    left0 = 0; left1 = 0; dest0 = '0; dest1 = '0; cnt0 = 0; cnt1 = 0;
    rst_n = 1'b0;
    clear_in();

    // Reset state
    sample();
    chk("rst_busy", 32'(if0.mdBusy), 32'(0));
    chk("rst_done", 32'(if0.mdDone), 32'(0));
    chk("rst_cnt", 32'(if0.stallCnt), 32'(0));
    advance();
    sample();
    advance();
    rst_n = 1'b1;

    // Forward priority M over W
    wrAddrM = 5; wrAddrW = 5; regWeM = 1; regWeW = 1; rsE = 5;
    sample(); chk("prio_M", 32'(if0.forwardAE), 32'(2'b01)); advance();
    regWeM = 0;
    sample(); chk("prio_W", 32'(if0.forwardAE), 32'(2'b10)); advance();
    rsE = 0;
    sample(); chk("prio_r0", 32'(if0.forwardAE), 32'(2'b00)); advance();

    // Load-use: one stall, then forwarded from M
    clear_in();
    memToRegE = 1; regWeE = 1; wrAddrE = 8; rtD = 8;
    sample(); chk("lu_stall", 32'({if0.stallF, if0.stallD, if0.flushE}), 32'(3'b111)); advance();
    clear_in();
    wrAddrM = 8; regWeM = 1; memToRegM = 1; rtE = 8;
    sample();
    chk("lu_release", 32'(if0.stallD), 32'(0));
    chk("lu_fwdBE", 32'(if0.forwardBE), 32'(2'b01));
    advance();

    // Branch in ID against an ALU result in EX, then in M
    clear_in();
    branchD = 1; rsD = 3; wrAddrE = 3; regWeE = 1;
    sample(); chk("br_stall", 32'(if0.stallD), 32'(1)); advance();
    regWeE = 0; wrAddrE = 0; wrAddrM = 3; regWeM = 1; memToRegM = 0;
    sample();
    chk("br_release", 32'(if0.stallD), 32'(0));
    chk("br_fwdAD", 32'(if0.forwardAD), 32'(1));
    advance();

    // Mul/div RAW: clear counter while launching
    clear_in();
    perfClr = 1; mdStartE = 1; mdDestE = 9;
    sample(); advance();
    clear_in();
    rsD = 9;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("md_busy", 32'(if0.mdBusy), 32'(1));
      chk("md_done", 32'(if0.mdDone), 32'(i == 3));
      chk("md_raw", 32'(if0.stallD), 32'(1));
      advance();
    end
    sample();
    chk("md_idle", 32'(if0.mdBusy), 32'(0));
    chk("md_rel", 32'(if0.stallD), 32'(0));
    chk("md_cnt4", 32'(if0.stallCnt), 32'(4));
    advance();

    // Mul/div structural: mdReqD released in the mdDone cycle
    clear_in();
    mdStartE = 1; mdDestE = 7;
    sample(); advance();
    clear_in();
    mdReqD = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("md_struct", 32'(if0.stallD), 32'(i < 3));
      advance();
    end
    sample(); advance();

    // No-forward instance: M match stalls, forwards stay 0
    clear_in();
    regWeM = 1; wrAddrM = 2; rsD = 2; rsE = 2;
    sample();
    chk("nf_stall", 32'(if1.stallD), 32'(1));
    chk("nf_fwdAE", 32'(if1.forwardAE), 32'(0));
    chk("nf_fwd0", 32'(if0.stallD), 32'(0));
    advance();

    // Saturation of the 4-bit counter, then clear while stalled
    perfClr = 1;
    sample(); advance();
    perfClr = 0;
    sample(); chk("sat_clr0", 32'(if1.stallCnt), 32'(0));
    advance();
    for (int i = 0; i < 19; i++) begin sample(); advance(); end
    sample(); chk("sat_15", 32'(if1.stallCnt), 32'(15)); advance();
    perfClr = 1;
    sample(); advance();
    sample(); chk("sat_clr", 32'(if1.stallCnt), 32'(0)); advance();

    // Asynchronous reset while busy
    clear_in();
    mdStartE = 1; mdDestE = 4;
    sample(); advance();
    clear_in();
    sample(); chk("rb_busy", 32'(if0.mdBusy), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rb_busy0", 32'(if0.mdBusy), 32'(0));
    chk("rb_done0", 32'(if0.mdDone), 32'(0));
    chk("rb_busy1", 32'(if1.mdBusy), 32'(0));
    left0 = 0; left1 = 0; dest0 = '0; dest1 = '0; cnt0 = 0; cnt1 = 0;
    rst_n = 1'b1;
    advance();

    // Randomized traffic over a small register range to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      rsD       = AW'($urandom_range(0, 3));
      rtD       = AW'($urandom_range(0, 3));
      rsE       = AW'($urandom_range(0, 3));
      rtE       = AW'($urandom_range(0, 3));
      wrAddrE   = AW'($urandom_range(0, 3));
      wrAddrM   = AW'($urandom_range(0, 3));
      wrAddrW   = AW'($urandom_range(0, 3));
      mdDestE   = AW'($urandom_range(0, 3));
      branchD   = 1'($urandom_range(0, 3) == 0);
      mdReqD    = 1'($urandom_range(0, 3) == 0);
      regWeE    = 1'($urandom_range(0, 1));
      memToRegE = 1'($urandom_range(0, 2) == 0);
      regWeM    = 1'($urandom_range(0, 1));
      memToRegM = 1'($urandom_range(0, 2) == 0);
      regWeW    = 1'($urandom_range(0, 1));
      mdStartE  = 1'($urandom_range(0, 7) == 0);
      perfClr   = 1'($urandom_range(0, 31) == 0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
